// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round scheduler: FSM states, block geometry
// and the message-schedule sigma functions.
package sha256_pkg;

    localparam int NUM_ROUNDS      = 64;
    localparam int WORDS_PER_BLOCK = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        LOAD,
        ROUNDS,
        UPDATE,
        DONE
    } state_t;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round_scheduler_if.sv
// Message-word fetch bus between the round scheduler and the padded-message store.
interface sha256_round_scheduler_if;
    logic        req_word;
    logic [7:0]  word_address;
    logic        word_valid;
    logic [31:0] word_data;

    modport master (
        output req_word,
        output word_address,
        input  word_valid,
        input  word_data
    );

    modport slave (
        input  req_word,
        input  word_address,
        output word_valid,
        output word_data
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// 16-entry circular W buffer: words 0..15 come from the fetch bus, later words
// are expanded in place as each round is issued.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        load_en,
    input  logic [3:0]  load_idx,
    input  logic [31:0] load_data,
    input  logic        issue_en,
    input  logic [5:0]  t,
    output logic [31:0] w_cur
);

    logic [31:0] w_buf [WORDS_PER_BLOCK];
    logic [31:0] w_exp;
    logic [3:0]  slot;

    assign slot = t[3:0];

    // slot holds W[t-16]; slot-15 wraps to W[t-15] in the circular buffer
    always_comb begin
        w_exp = sigma1(w_buf[slot - 4'd2]) + w_buf[slot - 4'd7]
              + sigma0(w_buf[slot - 4'd15]) + w_buf[slot];
        w_cur = (t < 6'd16) ? w_buf[slot] : w_exp;
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            w_buf[load_idx] <= load_data;
        end else if (issue_en && t >= 6'd16) begin
            w_buf[slot] <= w_exp;
        end
    end

endmodule

// File: rtl/sha256_round_scheduler.sv
// Sequences message fetch, 64-round scheduling and per-block/per-message control
// pulses for a SHA-256 compression core.
module sha256_round_scheduler
    import sha256_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 num_blocks,
    input  logic                       abort,
    input  logic                       round_hold,
    sha256_round_scheduler_if.master   mem,
    output logic                       hash_init,
    output logic                       block_load,
    output logic                       block_done,
    output logic                       digest_valid,
    output logic                       round_en,
    output logic [5:0]                 round_idx,
    output logic [31:0]                w_t,
    output logic                       busy
);

    state_t      state, state_next;
    logic [3:0]  block_cnt, word_idx, num_blocks_lat;
    logic [5:0]  round_cnt;
    logic        capture, issue, last_block;
    logic [31:0] w_cur;

    logic        hash_init_p1, block_load_p1, block_done_p1, digest_valid_p1, round_en_p1;
    logic [5:0]  round_idx_p1;
    logic [31:0] w_t_p1;

    assign capture           = (state == FETCH) && mem.word_valid && !abort;
    assign issue             = (state == ROUNDS) && !round_hold && !abort;
    assign last_block        = (block_cnt == num_blocks_lat);
    assign mem.word_address  = {block_cnt, word_idx};

    sha256_msg_schedule u_sched (
        .clk       (clk),
        .load_en   (capture),
        .load_idx  (word_idx),
        .load_data (mem.word_data),
        .issue_en  (issue),
        .t         (round_cnt),
        .w_cur     (w_cur)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b1;
        mem.req_word = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = INIT;
            end
            INIT:   state_next = FETCH;
            FETCH: begin
                mem.req_word = 1'b1;
                if (mem.word_valid && word_idx == 4'(WORDS_PER_BLOCK - 1)) state_next = LOAD;
            end
            LOAD:   state_next = ROUNDS;
            ROUNDS: if (!round_hold && round_cnt == 6'(NUM_ROUNDS - 1)) state_next = UPDATE;
            UPDATE: state_next = last_block ? DONE : FETCH;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && state != IDLE) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_cnt      <= '0;
            word_idx       <= '0;
            round_cnt      <= '0;
            num_blocks_lat <= '0;
        end else begin
            if (state == IDLE && start) begin
                block_cnt      <= '0;
                word_idx       <= '0;
                num_blocks_lat <= num_blocks;
            end
            if (capture) word_idx <= word_idx + 4'd1;
            if (state == LOAD) round_cnt <= '0;
            if (issue) round_cnt <= round_cnt + 6'd1;
            if (state == UPDATE && !abort && !last_block) begin
                block_cnt <= block_cnt + 4'd1;
                word_idx  <= '0;
            end
        end
    end

    // Output stage: core-facing strobes and round data are registered one cycle after the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_init_p1    <= 1'b0;
            block_load_p1   <= 1'b0;
            block_done_p1   <= 1'b0;
            digest_valid_p1 <= 1'b0;
            round_en_p1     <= 1'b0;
            round_idx_p1    <= '0;
            w_t_p1          <= '0;
        end else begin
            hash_init_p1    <= (state == INIT)   && !abort;
            block_load_p1   <= (state == LOAD)   && !abort;
            block_done_p1   <= (state == UPDATE) && !abort;
            digest_valid_p1 <= (state == DONE)   && !abort;
            round_en_p1     <= issue;
            if (state == LOAD) round_idx_p1 <= '0;
            if (issue) begin
                round_idx_p1 <= round_cnt;
                w_t_p1       <= w_cur;
            end
        end
    end

    assign hash_init    = hash_init_p1;
    assign block_load   = block_load_p1;
    assign block_done   = block_done_p1;
    assign digest_valid = digest_valid_p1;
    assign round_en     = round_en_p1;
    assign round_idx    = round_idx_p1;
    assign w_t          = w_t_p1;

endmodule

// File: tb/tb_sha256_round_scheduler.sv
// Directed bench for sha256_round_scheduler: latency, schedule words, fetch
// handshake, hold, abort, ignored start and mid-message reset.
module tb_sha256_round_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_blocks = 4'd0;
    logic        abort = 1'b0;
    logic        round_hold = 1'b0;
    logic        hash_init, block_load, block_done, digest_valid, round_en, busy;
    logic [5:0]  round_idx;
    logic [31:0] w_t;

    sha256_round_scheduler_if bus();

    logic [31:0] msg_mem [256];
    logic [31:0] wt_ref [64];
    bit          slow_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;

    // monitor accumulators (only the monitor writes these)
    int n_round = 0, n_init = 0, n_load = 0, n_done = 0, n_digest = 0;
    int dig_cyc = 0, hold_err = 0;
    int          addr_q [$];
    int          ridx_q [$];
    logic [31:0] wt_q [$];
    logic        prev_req = 1'b0, prev_cap = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    // per-run baselines
    int b_round, b_init, b_load, b_done, b_dig, b_hold, b_addr, b_wt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.word_data = msg_mem[bus.word_address];

    sha256_round_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_blocks   (num_blocks),
        .abort        (abort),
        .round_hold   (round_hold),
        .mem          (bus),
        .hash_init    (hash_init),
        .block_load   (block_load),
        .block_done   (block_done),
        .digest_valid (digest_valid),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .w_t          (w_t),
        .busy         (busy)
    );

    initial begin
        int vcnt;
        vcnt = 0;
        bus.word_valid = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (slow_mode) begin
                vcnt = (vcnt + 1) % 3;
                bus.word_valid = (vcnt == 0);
            end else begin
                bus.word_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (round_en) begin
            n_round <= n_round + 1;
            ridx_q.push_back(int'(round_idx));
            wt_q.push_back(w_t);
        end
        if (hash_init)  n_init <= n_init + 1;
        if (block_load) n_load <= n_load + 1;
        if (block_done) n_done <= n_done + 1;
        if (digest_valid) begin
            n_digest <= n_digest + 1;
            dig_cyc  <= cyc;
        end
        if (bus.req_word) begin
            if (prev_req && !prev_cap && bus.word_address != prev_addr) hold_err <= hold_err + 1;
            if (bus.word_valid) addr_q.push_back(int'(bus.word_address));
        end
        prev_req  <= bus.req_word;
        prev_cap  <= bus.word_valid;
        prev_addr <= bus.word_address;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_abc();
        for (int i = 0; i < 256; i++) msg_mem[i] = 32'h0;
        msg_mem[0]  = 32'h61626380;
        msg_mem[15] = 32'h00000018;
    endtask

    task automatic launch(input logic [3:0] nb);
        @(posedge clk); #1;
        b_round = n_round; b_init = n_init; b_load = n_load; b_done = n_done;
        b_dig = n_digest; b_hold = hold_err; b_addr = addr_q.size(); b_wt = wt_q.size();
        num_blocks = nb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num_blocks = 4'd0;
        start_edge = cyc;
    endtask

    task automatic wait_digest(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (n_digest > b_dig) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s digest_wait: no digest_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_round(input int idx, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #1;
            if (round_en && round_idx == 6'(idx)) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s round_wait: round %0d never issued", name, idx);
        end
    endtask

    task automatic check_abc_words(input string name);
        checks++;
        if (wt_q[b_wt+0] !== 32'h61626380 || wt_q[b_wt+15] !== 32'h00000018) begin
            errors++;
            $display("FAIL %s w0_w15: got %h %h expected 61626380 00000018", name, wt_q[b_wt+0], wt_q[b_wt+15]);
        end
        checks++;
        if (wt_q[b_wt+16] !== 32'h61626380) begin
            errors++;
            $display("FAIL %s w16: got %h expected 61626380", name, wt_q[b_wt+16]);
        end
        checks++;
        if (wt_q[b_wt+17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL %s w17: got %h expected 000f0000", name, wt_q[b_wt+17]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) msg_mem[i] = 32'h0;
        #12;
        checks++;
        if ({hash_init, block_load, block_done, digest_valid, round_en, busy, bus.req_word} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {hash_init, block_load, block_done, digest_valid, round_en, busy, bus.req_word});
        end
        checks++;
        if (bus.word_address !== 8'h00 || w_t !== 32'h0 || round_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_buses: got addr %h w_t %h idx %0d expected all 0", bus.word_address, w_t, round_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_abc();
        int bad;
        load_abc();
        launch(4'd0);
        wait_digest(300, "abc");
        checks++;
        if (dig_cyc - start_edge != 84) begin
            errors++;
            $display("FAIL abc_latency: got %0d expected 84", dig_cyc - start_edge);
        end
        checks++;
        if (n_round - b_round != 64 || n_init - b_init != 1 || n_load - b_load != 1 || n_done - b_done != 1) begin
            errors++;
            $display("FAIL abc_pulses: got rounds %0d init %0d load %0d done %0d expected 64 1 1 1",
                     n_round - b_round, n_init - b_init, n_load - b_load, n_done - b_done);
        end
        check_abc_words("abc");
        checks++;
        if (wt_q[b_wt+18] !== 32'h7DA86405) begin
            errors++;
            $display("FAIL abc_w18: got %h expected 7da86405", wt_q[b_wt+18]);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (ridx_q[b_wt+i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abc_round_idx: got %0d out-of-order indices expected 0", bad);
        end
        bad = (addr_q.size() - b_addr != 16) ? 1 : 0;
        for (int i = 0; i < 16; i++) if (addr_q[b_addr+i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abc_addresses: got %0d bad captures expected 0", bad);
        end
        checks++;
        if (busy !== 1'b0 || digest_valid !== 1'b0) begin
            errors++;
            $display("FAIL abc_after: got busy %b digest %b expected 0 0", busy, digest_valid);
        end
        for (int i = 0; i < 64; i++) wt_ref[i] = wt_q[b_wt+i];
    endtask

    task automatic test_multi_block();
        int bad;
        load_abc();
        for (int i = 0; i < 16; i++) msg_mem[16+i] = 32'h10000000 + i;
        launch(4'd1);
        wait_digest(500, "two_block");
        checks++;
        if (dig_cyc - start_edge != 166) begin
            errors++;
            $display("FAIL two_block_latency: got %0d expected 166", dig_cyc - start_edge);
        end
        checks++;
        if (n_init - b_init != 1 || n_done - b_done != 2 || n_round - b_round != 128) begin
            errors++;
            $display("FAIL two_block_pulses: got init %0d done %0d rounds %0d expected 1 2 128",
                     n_init - b_init, n_done - b_done, n_round - b_round);
        end
        bad = (addr_q.size() - b_addr != 32) ? 1 : 0;
        for (int i = 0; i < 32; i++) if (addr_q[b_addr+i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL two_block_addresses: got %0d bad captures expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (wt_q[b_wt+64+i] !== 32'h10000000 + i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL two_block_w2: got %0d wrong block-1 words expected 0", bad);
        end
    endtask

    task automatic test_slow_fetch();
        int bad;
        for (int i = 0; i < 16; i++) msg_mem[i] = 32'hC0DE0000 + i;
        slow_mode = 1'b1;
        launch(4'd0);
        wait_digest(500, "slow_fetch");
        slow_mode = 1'b0;
        bad = (addr_q.size() - b_addr != 16) ? 1 : 0;
        for (int i = 0; i < 16; i++) if (addr_q[b_addr+i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL slow_addresses: got %0d bad captures expected 0", bad);
        end
        checks++;
        if (hold_err - b_hold != 0) begin
            errors++;
            $display("FAIL slow_addr_held: got %0d address moves without capture expected 0", hold_err - b_hold);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (wt_q[b_wt+i] !== 32'hC0DE0000 + i) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL slow_words: got %0d wrong words expected 0", bad);
        end
    endtask

    task automatic test_round_hold();
        int bad;
        load_abc();
        launch(4'd0);
        wait_round(20, "hold");
        round_hold = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (round_en !== 1'b0 || round_idx !== 6'd20) bad++;
        end
        round_hold = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_freeze: got %0d cycles with round_en or moved index expected 0", bad);
        end
        wait_digest(300, "hold");
        checks++;
        if (dig_cyc - start_edge != 89) begin
            errors++;
            $display("FAIL hold_latency: got %0d expected 89", dig_cyc - start_edge);
        end
        bad = (n_round - b_round != 64) ? 1 : 0;
        for (int i = 0; i < 64; i++) if (wt_q[b_wt+i] !== wt_ref[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_schedule: got %0d differing words expected 0", bad);
        end
    endtask

    task automatic test_abort_restart();
        int bad;
        load_abc();
        launch(4'd0);
        wait_round(30, "abort");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || round_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy %b round_en %b expected 0 0", busy, round_en);
        end
        @(posedge clk); #1;
        checks++;
        if (n_digest != b_dig) begin
            errors++;
            $display("FAIL abort_no_digest: got %0d digests expected 0", n_digest - b_dig);
        end
        launch(4'd0);
        wait_digest(300, "restart");
        checks++;
        if (dig_cyc - start_edge != 84) begin
            errors++;
            $display("FAIL restart_latency: got %0d expected 84", dig_cyc - start_edge);
        end
        bad = (n_round - b_round != 64) ? 1 : 0;
        for (int i = 0; i < 64; i++) if (wt_q[b_wt+i] !== wt_ref[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_schedule: got %0d differing words expected 0", bad);
        end
    endtask

    task automatic test_start_busy_and_reset();
        bit seen;
        load_abc();
        launch(4'd0);
        wait_round(10, "busy_start");
        start = 1'b1;
        num_blocks = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        num_blocks = 4'd0;
        wait_digest(300, "busy_start");
        checks++;
        if (dig_cyc - start_edge != 84 || n_init - b_init != 1 || n_done - b_done != 1) begin
            errors++;
            $display("FAIL busy_start_ignored: got latency %0d init %0d done %0d expected 84 1 1",
                     dig_cyc - start_edge, n_init - b_init, n_done - b_done);
        end
        launch(4'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (addr_q.size() - b_addr >= 5 && bus.req_word) seen = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || {hash_init, block_load, block_done, digest_valid, round_en, busy, bus.req_word} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_flags: reached fetch %b got %b expected 0000000", seen,
                     {hash_init, block_load, block_done, digest_valid, round_en, busy, bus.req_word});
        end
        checks++;
        if (bus.word_address !== 8'h00 || w_t !== 32'h0 || round_idx !== 6'd0) begin
            errors++;
            $display("FAIL midreset_buses: got addr %h w_t %h idx %0d expected all 0", bus.word_address, w_t, round_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.req_word !== 1'b0) begin
            errors++;
            $display("FAIL postreset_idle: got busy %b req %b expected 0 0", busy, bus.req_word);
        end
        launch(4'd0);
        wait_digest(300, "postreset");
        checks++;
        if (dig_cyc - start_edge != 84) begin
            errors++;
            $display("FAIL postreset_latency: got %0d expected 84", dig_cyc - start_edge);
        end
        check_abc_words("postreset");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_multi_block();
        test_slow_fetch();
        test_round_hold();
        test_abort_restart();
        test_start_busy_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_round_scheduler.md
SHA256_ROUND_SCHEDULER -- requirements
Module: sha256_round_scheduler

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  begin hashing a padded message (one-cycle pulse).
REQ-004 SHALL have port num_blocks  input  4  number of 512-bit blocks minus 1; sampled at start.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the current message.
REQ-006 SHALL have port round_hold  input  1  core stall; freezes round sequencing.
REQ-007 SHALL have port word_valid  input  1  word_data valid for the current word_address.
REQ-008 SHALL have port word_data  input  32  message word, big-endian.
REQ-009 SHALL have port req_word  output  1  word fetch request.
REQ-010 SHALL have port word_address  output  8  {block_cnt[3:0], word_idx[3:0]}.
REQ-011 SHALL have ports hash_init, block_load, block_done, digest_valid  output  1 each  single-cycle core control pulses.
REQ-012 SHALL have ports round_en (1), round_idx (6), w_t (32), busy (1)  output  round strobe, round number t, schedule word W[t], active flag.

Function
REQ-013 SHALL implement the states IDLE, INIT, FETCH, LOAD, ROUNDS, UPDATE and DONE.
REQ-014 IDLE: start moves the block to INIT, clears block_cnt, and latches num_blocks; busy=0 only in IDLE.
REQ-015 INIT: lasts 1 cycle, asserts hash_init, then moves to FETCH.
REQ-016 FETCH: req_word=1 while word_address is held stable; each word_valid cycle captures word_data into W slot word_idx and increments word_idx; the capture of word 15 moves the block to LOAD; with no word_valid it waits indefinitely.
REQ-017 LOAD: lasts 1 cycle, asserts block_load, clears round_idx, then moves to ROUNDS.
REQ-018 ROUNDS: each cycle with round_hold=0 asserts round_en with round_idx=t and w_t=W[t], then increments t.
REQ-019 ROUNDS hold: round_hold=1 deasserts round_en and freezes t and the W buffer.
REQ-020 ROUNDS exit: after t=63 is issued the block moves to UPDATE.
REQ-021 W[t] source: for t<16, W[t] SHALL be buffer slot t.
REQ-022 W[t] expansion: for t>=16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32, written back to slot t mod 16 in the same cycle it is issued.
REQ-023 σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-024 UPDATE: lasts 1 cycle and asserts block_done; if block_cnt==latched num_blocks the block moves to DONE, else block_cnt increments, word_idx is cleared, and the block moves to FETCH.
REQ-025 DONE: lasts 1 cycle, asserts digest_valid, then returns to IDLE.
REQ-026 Latency: with word_valid always 1 and no hold, digest_valid SHALL occur 84 cycles after the start edge for 1 block, plus 82 cycles per additional block.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL return the block to IDLE on the next edge with no digest_valid; abort has priority over all other transitions.
REQ-029 num_blocks=15 SHALL fetch addresses up to 0xFF; block_cnt SHALL NOT wrap.
REQ-030 Outside their states, req_word, round_en and all pulses SHALL be 0; w_t is don't-care when round_en=0.

Reset
REQ-031 On rst_n low, state SHALL be IDLE and block_cnt, word_idx, round_idx and the latched num_blocks SHALL be 0.
REQ-032 On rst_n low, every 1-bit output SHALL be 0 and word_address and w_t SHALL be 0; the W buffer need not be cleared.
REQ-033 Reset mid-message SHALL discard all progress; the first start after release SHALL behave as in REQ-026.

Structure
REQ-034 Shared package sha256_pkg SHALL hold the state enum, NUM_ROUNDS=64, WORDS_PER_BLOCK=16, and the σ0/σ1 functions.
REQ-035 The 16x32 W circular buffer with its expansion logic SHALL be the sub-module sha256_msg_schedule; sequencing SHALL stay in the top module.

Verification
REQ-036 Scenario "abc", 1 block (W0=0x61626380, W15=0x00000018, others 0), num_blocks=0, word_valid tied 1 -> W16=0x61626380, W17=0x000F0000, 64 round_en pulses, digest_valid at cycle 84.
REQ-037 Scenario 2 blocks, num_blocks=1 -> addresses 0x00-0x0F then 0x10-0x1F, 2 block_done pulses, 1 hash_init pulse, digest_valid at cycle 166.
REQ-038 Scenario word_valid only every 3rd cycle during FETCH -> word_address held between captures, 16 captures in order, no word skipped.
REQ-039 Scenario round_hold=1 for 5 cycles at t=20 -> round_idx stays 20, W buffer unchanged, digest_valid delayed by exactly 5 cycles.
REQ-040 Scenario abort at t=30 followed by start 2 cycles later -> no digest_valid for the aborted message; the second run matches REQ-036.
REQ-041 Scenario start pulsed during ROUNDS, plus rst_n low during FETCH -> the start is ignored; after reset all outputs are 0 and the state is IDLE.
